// File: rtl/regfile_wb_sched_if.sv
// Writeback bus between the requesters, the scheduler and the register-file write port.
interface regfile_wb_sched_if #(
  parameter int unsigned NREQ = 3
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [5*NREQ-1:0]  req_regnum;
  logic [32*NREQ-1:0] req_data;
  logic               RegWrite;
  logic [4:0]         WbRegNum;
  logic [31:0]        WbData;

  modport master (
    output req_valid, req_regnum, req_data,
    input  req_ready, RegWrite, WbRegNum, WbData
  );

  modport slave (
    input  req_valid, req_regnum, req_data,
    output req_ready, RegWrite, WbRegNum, WbData
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback arbiter onto the single register-file write port plus pending-write scoreboard.
// Define WB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module regfile_wb_sched #(
  parameter int unsigned NREQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_sched_if.slave  bus,
  input  logic               iss_valid,
  input  logic [4:0]         iss_regnum,
  input  logic [4:0]         rs1_num,
  input  logic [4:0]         rs2_num,
  output logic               rs1_busy,
  output logic               rs2_busy
);

  localparam int unsigned PtrW = $clog2(NREQ);

  logic [PtrW-1:0] gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] gnt;
  logic [4:0]      sel_num;
  logic [31:0]     sel_data;

  logic            regwrite_q;
  logic [4:0]      wb_regnum_q;
  logic [31:0]     wb_data_q;
  logic [31:0]     busy_q, busy_d;

`ifdef WB_FIXED_PRIO_EN
  // Scan from the top down so the lowest valid index is the last (winning) assignment.
  always_comb begin
    gnt_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_idx = PtrW'(i);
      end
    end
  end
`else
  logic [PtrW-1:0] ptr_q;

  // Scan offsets from farthest to nearest so the first valid after ptr wins.
  always_comb begin
    int unsigned cand;
    gnt_idx = '0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      cand = (32'(ptr_q) + off) % NREQ;
      if (bus.req_valid[PtrW'(cand)]) begin
        gnt_idx = PtrW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PtrW'(NREQ - 1);
    end else if (gnt_any) begin
      ptr_q <= gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt_any  = |bus.req_valid;
    gnt      = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    sel_num  = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == PtrW'(i)) begin
        sel_num  = bus.req_regnum[5*i +: 5];
        sel_data = bus.req_data[32*i +: 32];
      end
    end
  end

  assign bus.req_ready = gnt;

  // A set from decode overrides a clear from the write port on the same edge.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) begin
      busy_d[wb_regnum_q] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_regnum] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q  <= 1'b0;
      wb_regnum_q <= '0;
      wb_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      busy_q <= busy_d;
      if (gnt_any) begin
        // Writes to x0 consume the slot but never reach the register file.
        regwrite_q  <= (sel_num != 5'd0);
        wb_regnum_q <= sel_num;
        wb_data_q   <= sel_data;
      end else begin
        regwrite_q <= 1'b0;
      end
    end
  end

  assign bus.RegWrite = regwrite_q;
  assign bus.WbRegNum = wb_regnum_q;
  assign bus.WbData   = wb_data_q;

  assign rs1_busy = busy_q[rs1_num];
  assign rs2_busy = busy_q[rs2_num];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: per-cycle model comparison plus literal spot checks.
module tb_regfile_wb_sched;
  localparam int NREQ = 3;

  logic       clk;
  logic       rst;
  logic       iss_valid;
  logic [4:0] iss_regnum;
  logic [4:0] rs1_num;
  logic [4:0] rs2_num;
  logic       rs1_busy;
  logic       rs2_busy;

  regfile_wb_sched_if #(.NREQ(NREQ)) bus ();

  regfile_wb_sched #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .iss_valid  (iss_valid),
    .iss_regnum (iss_regnum),
    .rs1_num    (rs1_num),
    .rs2_num    (rs2_num),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level state of the port and the pending-write set.
  int          m_ptr;
  bit   [31:0] m_busy;
  bit          m_rw;
  bit   [4:0]  m_num;
  bit   [31:0] m_data;

  function automatic int grant_of(input logic [NREQ-1:0] v, input int p);
`ifdef WB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    int          g;
    bit   [31:0] nb;
    bit   [4:0]  rn;
    if (rst) begin
      m_ptr  <= NREQ - 1;
      m_busy <= '0;
      m_rw   <= 1'b0;
      m_num  <= '0;
      m_data <= '0;
    end else begin
      g  = grant_of(bus.req_valid, m_ptr);
      nb = m_busy;
      if (m_rw) nb[m_num] = 1'b0;
      if (iss_valid && iss_regnum != 0) nb[iss_regnum] = 1'b1;
      m_busy <= nb;
      if (g >= 0) begin
        rn = bus.req_regnum[5*g +: 5];
        m_rw   <= (rn != 0);
        m_num  <= rn;
        m_data <= bus.req_data[32*g +: 32];
        m_ptr  <= g;
      end else begin
        m_rw <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int          g;
    logic [31:0] er;
    if (started) begin
      g  = grant_of(bus.req_valid, m_ptr);
      er = (g < 0) ? 32'd0 : (32'd1 << g);
      check("m_ready", 32'(bus.req_ready), er);
      check("m_regwrite", 32'(bus.RegWrite), 32'(m_rw));
      check("m_wbregnum", 32'(bus.WbRegNum), 32'(m_num));
      check("m_wbdata", bus.WbData, m_data);
      check("m_rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_num]));
      check("m_rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_num]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int order [6];
    rst            = 1'b1;
    iss_valid      = 1'b0;
    iss_regnum     = '0;
    rs1_num        = '0;
    rs2_num        = '0;
    bus.req_valid  = '0;
    bus.req_regnum = '0;
    bus.req_data   = '0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_wbregnum", 32'(bus.WbRegNum), 32'd0);
    check("rst_wbdata", bus.WbData, 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);

    // Single request from requester 1
    tick();
    bus.req_valid        = 3'b010;
    bus.req_regnum[9:5]  = 5'd5;
    bus.req_data[63:32]  = 32'hDEADBEEF;
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_regwrite", 32'(bus.RegWrite), 32'd1);
    check("single_wbregnum", 32'(bus.WbRegNum), 32'd5);
    check("single_wbdata", bus.WbData, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("single_regwrite_off", 32'(bus.RegWrite), 32'd0);

    // Fairness from reset with all requesters valid
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid  = 3'b111;
    bus.req_regnum = {5'd12, 5'd11, 5'd10};
    bus.req_data   = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
`ifdef WB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_order", 32'(bus.req_ready), 32'd1 << order[k]);
      tick();
    end
    bus.req_valid = '0;

    // Scoreboard round trip on register 7
    iss_valid  = 1'b1;
    iss_regnum = 5'd7;
    rs1_num    = 5'd7;
    @(negedge clk);
    check("sb_before_set", 32'(rs1_busy), 32'd0);
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    check("sb_set", 32'(rs1_busy), 32'd1);
    tick();
    bus.req_valid       = 3'b001;
    bus.req_regnum[4:0] = 5'd7;
    bus.req_data[31:0]  = 32'h0000_0077;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("sb_wb_regwrite", 32'(bus.RegWrite), 32'd1);
    check("sb_wb_regnum", 32'(bus.WbRegNum), 32'd7);
    check("sb_busy_during_wb", 32'(rs1_busy), 32'd1);
    tick();
    @(negedge clk);
    check("sb_cleared", 32'(rs1_busy), 32'd0);

    // Simultaneous set and clear on register 9
    tick();
    iss_valid  = 1'b1;
    iss_regnum = 5'd9;
    rs2_num    = 5'd9;
    tick();
    iss_valid             = 1'b0;
    bus.req_valid         = 3'b100;
    bus.req_regnum[14:10] = 5'd9;
    bus.req_data[95:64]   = 32'h0000_0099;
    @(negedge clk);
    check("sc_busy_pre", 32'(rs2_busy), 32'd1);
    tick();
    bus.req_valid = '0;
    iss_valid     = 1'b1;
    iss_regnum    = 5'd9;
    @(negedge clk);
    check("sc_regwrite", 32'(bus.RegWrite), 32'd1);
    check("sc_wbregnum", 32'(bus.WbRegNum), 32'd9);
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    check("sc_busy_kept", 32'(rs2_busy), 32'd1);

    // Register 0 requests and issues
    tick();
    rst = 1'b1;
    tick();
    rst                 = 1'b0;
    bus.req_valid       = 3'b001;
    bus.req_regnum[4:0] = 5'd0;
    bus.req_data[31:0]  = 32'h1234_5678;
    iss_valid           = 1'b1;
    iss_regnum          = 5'd0;
    rs1_num             = 5'd0;
    @(negedge clk);
    check("r0_ready", 32'(bus.req_ready), 32'h1);
    tick();
    iss_valid            = 1'b0;
    bus.req_valid        = 3'b011;
    bus.req_regnum[9:5]  = 5'd1;
    bus.req_data[63:32]  = 32'h0000_0011;
    @(negedge clk);
    check("r0_regwrite", 32'(bus.RegWrite), 32'd0);
    check("r0_rs1_busy", 32'(rs1_busy), 32'd0);
`ifdef WB_FIXED_PRIO_EN
    check("r0_ptr_next", 32'(bus.req_ready), 32'h1);
`else
    check("r0_ptr_next", 32'(bus.req_ready), 32'h2);
`endif
    tick();
    bus.req_valid = '0;

    // Reset while a write is in flight and register 3 is busy
    tick();
    iss_valid  = 1'b1;
    iss_regnum = 5'd3;
    tick();
    iss_valid           = 1'b0;
    bus.req_valid       = 3'b001;
    bus.req_regnum[4:0] = 5'd3;
    bus.req_data[31:0]  = 32'h0000_0033;
    tick();
    bus.req_valid         = 3'b100;
    bus.req_regnum[14:10] = 5'd12;
    rst                   = 1'b1;
    rs1_num               = 5'd3;
    @(negedge clk);
    check("mr_regwrite_pre", 32'(bus.RegWrite), 32'd1);
    check("mr_wbregnum_pre", 32'(bus.WbRegNum), 32'd3);
    check("mr_busy_pre", 32'(rs1_busy), 32'd1);
    tick();
    rst           = 1'b0;
    bus.req_valid = 3'b011;
    @(negedge clk);
    check("mr_regwrite", 32'(bus.RegWrite), 32'd0);
    check("mr_busy3", 32'(rs1_busy), 32'd0);
    check("mr_busy9", 32'(rs2_busy), 32'd0);
    check("mr_prio0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Writeback scheduler and scoreboard for the 32x32 register file in the pipelined CPU. It arbitrates NREQ writeback sources (ALU, load unit, mul/div) onto the register file's single write port (RegWrite/WbRegNum/WbData) through one registered output stage. It also keeps a per-register pending-write scoreboard, so decode can stall on operands that are not yet written back.

## Interface
- NREQ, 3: number of writeback requesters; legal range 2..4.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a writeback pending.
- req_ready  out  NREQ  requester i is granted this cycle; transfer when valid&&ready.
- req_regnum  in  5*NREQ  destination register of requester i, in bits [5i+4:5i].
- req_data  in  32*NREQ  write data of requester i, in bits [32i+31:32i].
- RegWrite  out  1  register-file write enable; registered.
- WbRegNum  out  5  register-file write address; registered.
- WbData  out  32  register-file write data; registered.
- iss_valid  in  1  decode issues an instruction that will write iss_regnum.
- iss_regnum  in  5  destination of the issuing instruction.
- rs1_num, rs2_num  in  5 each  decode source operands.
- rs1_busy, rs2_busy  out  1 each  operand has an uncommitted pending write; combinational from scoreboard.

## Operation
- Arbiter:
  - req_ready is combinational from req_valid and the priority pointer.
  - At most one requester is granted per cycle; a requester with valid=0 is never granted.
  - Some requester is granted in every cycle where any req_valid=1; the port never back-pressures all requesters.
  - Round robin: search starts at index ptr+1 mod NREQ. On a grant, ptr is updated to the granted index.
  - Reset sets ptr=NREQ-1, so requester 0 has highest priority first.
- Output stage, updated on a grant:
  - RegWrite <= (granted regnum != 0).
  - WbRegNum <= granted regnum; WbData <= granted data.
- Output stage, no grant: RegWrite <= 0; WbRegNum and WbData hold their values.
- Requests to register 0 are accepted (ready=1) and dropped. They produce RegWrite=0 and consume the arbitration slot, and ptr still advances.
- Scoreboard: busy[31:0].
  - Set: iss_valid && iss_regnum!=0 sets busy[iss_regnum].
  - Clear: busy[WbRegNum] clears at the posedge ending a cycle with RegWrite=1.
  - Same register set and cleared at the same edge: set wins; busy stays 1 for the new pending write.
  - busy[0] is constantly 0.
  - rsN_busy = busy[rsN_num].
- Issuing a register that is already busy (WAW) only keeps the bit set; no counting. Decode must not issue a WAW to a register that is still busy.
- Reset values: RegWrite=0, WbRegNum=0, WbData=0, busy=all 0, req_ready reflects current valids.
- Reset mid-operation:
  - An in-flight output write is squashed (RegWrite=0 the next cycle).
  - Grants asserted in the reset cycle are not transferred.
  - Requesters must re-present them.

## Timing
- Grant to RegWrite: 1 cycle. The request accepted at edge k appears on the port during cycle k..k+1, and the register file captures it at the following negedge.
- Busy clears at the posedge ending the RegWrite cycle. rsN_busy=0 is first visible in the cycle after the write, when the register file already holds the new value.
- Throughput: one writeback per cycle, aggregate across all requesters.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- Maximum wait for a continuously valid requester: NREQ-1 cycles.
- Combinational paths: req_valid->req_ready and rs*_num->rs*_busy only. No combinational path from any input to RegWrite, WbRegNum or WbData.

## Configuration
- WB_FIXED_PRIO_EN defined: fixed priority, lowest index always wins, ptr logic removed. Starvation of higher indices is permitted.
- WB_FIXED_PRIO_EN undefined (default): round robin as specified above.

## Test plan
- Reset, then single request: req_valid=3'b010, regnum=5, data=32'hDEADBEEF.
  - Required: req_ready=3'b010 in the same cycle.
  - Required: RegWrite=1, WbRegNum=5, WbData=32'hDEADBEEF in the next cycle, then RegWrite=0.
- All three valid continuously for 6 cycles from reset (no WB_FIXED_PRIO_EN):
  - Required grant order 0,1,2,0,1,2.
  - With WB_FIXED_PRIO_EN the required order is 0,0,0,0,0,0.
- Scoreboard round trip:
  - iss_valid with iss_regnum=7 -> rs1_busy=1 for rs1_num=7 from the next cycle.
  - Writeback to reg 7 -> rs1_busy=0 in the cycle after RegWrite=1.
- Simultaneous set and clear: iss_regnum=9 issued in the same cycle as RegWrite=1 with WbRegNum=9 -> busy[9] remains 1 afterwards.
- Register 0:
  - Request to reg 0 -> ready=1, RegWrite=0, ptr advances.
  - iss_regnum=0 -> rs1_busy=0 for rs1_num=0.
- Reset mid-operation: rst=1 while RegWrite=1 and busy[3]=1 -> the next cycle shows RegWrite=0, all busy bits 0, and requester 0 has highest priority.
